// File: rtl/parking_occupancy_ctrl_if.sv
// Gate sensor and display bus for the parking occupancy controller.
// master = controller side, slave = sensor/display side.
interface parking_occupancy_ctrl_if;
  logic       sensor_a;
  logic       sensor_b;
  logic [3:0] free_ones;
  logic [3:0] free_tens;
  logic       lot_full;
  logic       car_in;
  logic       car_out;
  logic       fault;

  modport master (
    input  sensor_a, sensor_b,
    output free_ones, free_tens,
    output lot_full, car_in, car_out, fault
  );

  modport slave (
    output sensor_a, sensor_b,
    input  free_ones, free_tens,
    input  lot_full, car_in, car_out, fault
  );
endinterface

// File: rtl/parking_occupancy_ctrl.sv
// Parking gate controller: sensor filtering, entry/exit sequencing
// and a saturating two-digit BCD free-space count.
module parking_occupancy_ctrl #(
  parameter int CAPACITY   = 20,
  parameter int DEB_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  parking_occupancy_ctrl_if.master bus
);

  localparam int DW =
    (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [3:0] CAP_T = 4'(CAPACITY / 10);
  localparam logic [3:0] CAP_O = 4'(CAPACITY % 10);

  typedef enum logic [2:0] {
    IDLE, EN_A, EN_AB, EN_B,
    EX_B, EX_AB, EX_A, WAIT_CLR
  } state_t;

  logic [1:0] raw;
  logic [1:0] filt;

  assign raw = {bus.sensor_a, bus.sensor_b};

  for (genvar i = 0; i < 2; i++) begin : g_deb
    logic          s1_q, s2_q, f_q;
    logic [DW-1:0] cnt_q;

    // Two-flop synchronizer, then a stability counter per beam.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        s1_q  <= 1'b0;
        s2_q  <= 1'b0;
        f_q   <= 1'b0;
        cnt_q <= '0;
      end else begin
        s1_q <= raw[i];
        s2_q <= s1_q;
        if (s2_q == f_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DEB_LAST) begin
          f_q   <= s2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign filt[i] = f_q;
  end

  state_t state_q, state_d;
  logic   entry_ev, exit_ev, seq_fault;

  // Sequencer state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and completion events from the filtered {a,b} pair.
  always_comb begin
    state_d   = state_q;
    entry_ev  = 1'b0;
    exit_ev   = 1'b0;
    seq_fault = 1'b0;
    unique case (state_q)
      IDLE: begin
        case (filt)
          2'b10:   state_d = EN_A;
          2'b01:   state_d = EX_B;
          2'b11:   begin state_d = WAIT_CLR; seq_fault = 1'b1; end
          default: state_d = IDLE;
        endcase
      end
      EN_A: begin
        case (filt)
          2'b11:   state_d = EN_AB;
          2'b00:   state_d = IDLE;
          2'b10:   state_d = EN_A;
          default: begin state_d = WAIT_CLR; seq_fault = 1'b1; end
        endcase
      end
      EN_AB: begin
        case (filt)
          2'b01:   state_d = EN_B;
          2'b10:   state_d = EN_A;
          2'b11:   state_d = EN_AB;
          default: begin state_d = WAIT_CLR; seq_fault = 1'b1; end
        endcase
      end
      EN_B: begin
        case (filt)
          2'b00:   begin state_d = IDLE; entry_ev = 1'b1; end
          2'b11:   state_d = EN_AB;
          2'b01:   state_d = EN_B;
          default: begin state_d = WAIT_CLR; seq_fault = 1'b1; end
        endcase
      end
      EX_B: begin
        case (filt)
          2'b11:   state_d = EX_AB;
          2'b00:   state_d = IDLE;
          2'b01:   state_d = EX_B;
          default: begin state_d = WAIT_CLR; seq_fault = 1'b1; end
        endcase
      end
      EX_AB: begin
        case (filt)
          2'b10:   state_d = EX_A;
          2'b01:   state_d = EX_B;
          2'b11:   state_d = EX_AB;
          default: begin state_d = WAIT_CLR; seq_fault = 1'b1; end
        endcase
      end
      EX_A: begin
        case (filt)
          2'b00:   begin state_d = IDLE; exit_ev = 1'b1; end
          2'b11:   state_d = EX_AB;
          2'b10:   state_d = EX_A;
          default: begin state_d = WAIT_CLR; seq_fault = 1'b1; end
        endcase
      end
      WAIT_CLR: begin
        if (filt == 2'b00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic [3:0] ones_q, tens_q;
  logic       full_q, in_q, out_q, fault_q;
  logic       is_zero, is_cap;

  assign is_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
  assign is_cap  = (tens_q == CAP_T) && (ones_q == CAP_O);

  // Saturating BCD free count and the one-clock event pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ones_q  <= CAP_O;
      tens_q  <= CAP_T;
      full_q  <= 1'b0;
      in_q    <= 1'b0;
      out_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      in_q    <= 1'b0;
      out_q   <= 1'b0;
      fault_q <= seq_fault;
      if (entry_ev) begin
        if (is_zero) begin
          fault_q <= 1'b1;
        end else begin
          in_q   <= 1'b1;
          full_q <= (tens_q == 4'd0) && (ones_q == 4'd1);
          if (ones_q == 4'd0) begin
            ones_q <= 4'd9;
            tens_q <= tens_q - 4'd1;
          end else begin
            ones_q <= ones_q - 4'd1;
          end
        end
      end else if (exit_ev) begin
        if (is_cap) begin
          fault_q <= 1'b1;
        end else begin
          out_q  <= 1'b1;
          full_q <= 1'b0;
          if (ones_q == 4'd9) begin
            ones_q <= 4'd0;
            tens_q <= tens_q + 4'd1;
          end else begin
            ones_q <= ones_q + 4'd1;
          end
        end
      end
    end
  end

  assign bus.free_ones = ones_q;
  assign bus.free_tens = tens_q;
  assign bus.lot_full  = full_q;
  assign bus.car_in    = in_q;
  assign bus.car_out   = out_q;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Scoreboard bench for parking_occupancy_ctrl with CAPACITY=3,
// DEB_CYCLES=4: directed gate sequences, events checked by a monitor.
module tb_parking_occupancy_ctrl;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  parking_occupancy_ctrl_if bus();

  parking_occupancy_ctrl #(
    .CAPACITY  (3),
    .DEB_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       ci;
    logic       co;
    logic       f;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       full;
  } ev_t;

  ev_t exp_q[$];

  ev_t got;
  ev_t want;

  always @(negedge clock) begin
    if (!reset && (bus.car_in || bus.car_out || bus.fault)) begin
      got = {bus.car_in, bus.car_out, bus.fault,
             bus.free_tens, bus.free_ones, bus.lot_full};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event got=%h required=none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL event got=%h required=%h", got, want);
        end
      end
    end
  end

  task automatic chk(input string name,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic ci, input logic co,
                      input logic f, input logic [3:0] t,
                      input logic [3:0] o, input logic full);
    exp_q.push_back({ci, co, f, t, o, full});
  endtask

  task automatic hold(input logic [1:0] p);
    bus.sensor_a = p[1];
    bus.sensor_b = p[0];
    repeat (10) @(negedge clock);
  endtask

  task automatic drain(input string name);
    repeat (4) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_ones", 8'(bus.free_ones), 8'd3);
    chk("rst_tens", 8'(bus.free_tens), 8'd0);
    chk("rst_full", 8'(bus.lot_full), 8'd0);
    chk("rst_pulses",
        8'({bus.car_in, bus.car_out, bus.fault}), 8'd0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic entry();
    hold(2'b10); hold(2'b11); hold(2'b01); hold(2'b00);
  endtask

  task automatic exit_seq();
    hold(2'b01); hold(2'b11); hold(2'b10); hold(2'b00);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.sensor_a = 1'b0;
    bus.sensor_b = 1'b0;
    repeat (2) @(negedge clock);
    do_reset();
    hold(2'b00);

    push(1, 0, 0, 4'd0, 4'd2, 0);
    entry();
    drain("entry1");
    chk("entry1_ones", 8'(bus.free_ones), 8'd2);

    push(1, 0, 0, 4'd0, 4'd1, 0);
    entry();
    push(1, 0, 0, 4'd0, 4'd0, 1);
    entry();
    drain("entry3");
    chk("full_flag", 8'(bus.lot_full), 8'd1);
    push(0, 0, 1, 4'd0, 4'd0, 1);
    entry();
    drain("entry_when_full");
    chk("full_ones", 8'(bus.free_ones), 8'd0);

    @(negedge clock);
    do_reset();
    push(0, 0, 1, 4'd0, 4'd3, 0);
    exit_seq();
    drain("exit_at_cap");
    push(1, 0, 0, 4'd0, 4'd2, 0);
    entry();
    push(0, 1, 0, 4'd0, 4'd3, 0);
    exit_seq();
    drain("exit_after_entry");
    chk("exit_ones", 8'(bus.free_ones), 8'd3);

    hold(2'b10); hold(2'b11); hold(2'b10); hold(2'b00);
    bus.sensor_a = 1'b1;
    repeat (2) @(negedge clock);
    bus.sensor_a = 1'b0;
    repeat (10) @(negedge clock);
    drain("backout_glitch");
    chk("backout_ones", 8'(bus.free_ones), 8'd3);

    hold(2'b10);
    push(0, 0, 1, 4'd0, 4'd3, 0);
    hold(2'b01);
    hold(2'b11);
    hold(2'b00);
    drain("illegal_jump");
    push(1, 0, 0, 4'd0, 4'd2, 0);
    entry();
    drain("entry_after_clear");

    hold(2'b10); hold(2'b11); hold(2'b01);
    do_reset();
    repeat (10) @(negedge clock);
    hold(2'b00);
    drain("reset_in_en_b");
    chk("post_reset_ones", 8'(bus.free_ones), 8'd3);
    chk("post_reset_full", 8'(bus.lot_full), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/parking_occupancy_ctrl.md
# parking_occupancy_ctrl

Sequencing controller for the parking-lot display path. It filters two beam-break sensors at the lot gate and decodes the order in which they break to detect car entries and exits. It keeps a saturating BCD count of free spaces and drives the two BCD digit inputs of the two-digit seven-segment multiplexer. It also flags the lot-full condition and sensor faults.

## Interface
- CAPACITY, 20 — lot size; free count after reset; legal range 1..99.
- DEB_CYCLES, 500000 — consecutive stable clocks required before a filtered sensor changes (5 ms at 100 MHz).
- clock  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-high; clears all state.
- sensor_a  in  1  outer beam, 1 = blocked; asynchronous to clock.
- sensor_b  in  1  inner beam, 1 = blocked; asynchronous to clock.
- free_ones  out  4  BCD ones digit of free spaces; feeds display digit1.
- free_tens  out  4  BCD tens digit of free spaces; feeds display digit2.
- lot_full  out  1  1 when free count = 0.
- car_in  out  1  one-clock pulse per counted entry.
- car_out  out  1  one-clock pulse per counted exit.
- fault  out  1  one-clock pulse on an illegal sensor sequence or count saturation.

## Operation
- Input conditioning, per sensor: two-flop synchronizer, then debounce. Keep a counter sized for DEB_CYCLES. Clear it whenever the synchronized value equals the filtered value. Otherwise increment it. When it reaches DEB_CYCLES-1, load the filtered value and clear the counter. Filtered values reset to 0.
- The FSM samples the filtered pair {a,b} every clock. States: IDLE, EN_A, EN_AB, EN_B, EX_B, EX_AB, EX_A, WAIT_CLR.
- IDLE: on 10 go to EN_A; on 01 go to EX_B; on 11 go to WAIT_CLR and pulse fault.
- Entry path:
  - EN_A: 11 → EN_AB; 00 → IDLE (car backed out, no count).
  - EN_AB: 01 → EN_B; 10 → EN_A.
  - EN_B: 00 → IDLE and count an entry; 11 → EN_AB.
- Exit path, mirror image:
  - EX_B: 11 → EX_AB; 00 → IDLE.
  - EX_AB: 10 → EX_A; 01 → EX_B.
  - EX_A: 00 → IDLE and count an exit; 11 → EX_AB.
- Any pair not listed for the current state (for example 01 in EN_A, 00 in EN_AB) goes to WAIT_CLR and pulses fault.
- WAIT_CLR: stay until 00, then go to IDLE. Nothing is counted.
- Free count, held as two BCD digits:
  - Entry: if the count is nonzero, decrement (ones 0 → 9 with tens−1) and pulse car_in. If the count is zero, leave it unchanged, pulse fault, and do not pulse car_in.
  - Exit: if the count is below CAPACITY, increment (ones 9 → 0 with tens+1) and pulse car_out. If the count equals CAPACITY, leave it unchanged, pulse fault, and do not pulse car_out.
- Entry and exit cannot complete in the same clock (single FSM), so no arbitration is needed.
- Digits never leave 0..9 and the count never leaves 0..CAPACITY.

## Timing
- Reset values:
  - FSM = IDLE; filtered sensors = 0.
  - free_tens = CAPACITY/10, free_ones = CAPACITY%10.
  - lot_full = 0; car_in = car_out = fault = 0.
- Sensor latency: a raw level change held stable reaches the filtered value 2 + DEB_CYCLES clocks later. Glitches shorter than DEB_CYCLES clocks are not propagated.
- Event latency: the clock edge on which the FSM samples the final 00 updates the state, the digits and lot_full, and raises the pulse. All of these become visible together in the following cycle. Pulses are exactly one clock wide.
- All outputs are registered; there is no combinational path from sensor inputs to outputs.
- Reset asserted mid-sequence: everything returns to reset values immediately and any partial entry or exit is discarded. After release, a pair still reading nonzero is handled from IDLE per the rules above.

## Test plan
- Test parameters for all scenarios: CAPACITY=3, DEB_CYCLES=4.
- Reset, then a full entry sequence 00→10→11→01→00, each level held 10 clocks → one car_in pulse; digits go 0,3 → 0,2; fault stays 0.
- Three entries, then a fourth → after the third, lot_full=1 and digits 0,0; the fourth gives fault pulse, no car_in, and digits stay 0,0.
- Exit sequence 00→01→11→10→00 from a count of 3 → fault pulse, count stays 3. After one entry, the same exit sequence gives car_out and count 3.
- Back-out 00→10→11→10→00, and a 2-clock glitch on sensor_a → no pulses, count unchanged.
- Illegal jump 10→01 (both sensors flip together and stay stable) → fault pulse and FSM in WAIT_CLR. Holding 11 keeps it there; 00 returns to IDLE with no count.
- Reset asserted while in EN_B → immediate return to digits 0,3 and IDLE; the following 00 produces no car_in.
